bus_cycle_sequencer: RTL and testbench

BUS_CYCLE_SEQUENCER -- requirements
Module: bus_cycle_sequencer

---
 rtl/bus_cycle_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// T-state sequencer for opcode fetch, memory and IO machine cycles.
// Every output is decoded from the state register and the latched cycle type.
//
//   state | meaning
//   IDLE  | no cycle in progress; a valid start launches T1
//   T1    | address phase; address latch written
//   T2    | strobe phase; nWAIT sampled (IO always inserts one wait)
//   TW    | wait state; repeats while nWAIT is low
//   T3    | data phase; final state except for an opcode fetch
//   T4    | refresh phase of an opcode fetch; final state
module bus_cycle_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] cycle_type,
   input  logic       nWAIT,
   input  logic       r_we,
   input  logic [7:0] r_in,
   output logic       busy,
   output logic       done,
   output logic [2:0] tstate,
   output logic       bus_ab_pin_we,
   output logic       pin_control_oe,
   output logic       bus_db_pin_re,
   output logic       bus_db_pin_oe,
   output logic       ctl_bus_db_we,
   output logic       rfsh_sel,
   output logic [7:0] r_reg,
   output logic       nM1,
   output logic       nMREQ,
   output logic       nIORQ,
   output logic       nRD,
   output logic       nWR,
   output logic       nRFSH
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T1   = 3'd1;
   localparam logic [2:0] S_T2   = 3'd2;
   localparam logic [2:0] S_TW   = 3'd3;
   localparam logic [2:0] S_T3   = 3'd4;
   localparam logic [2:0] S_T4   = 3'd5;

   localparam logic [2:0] CT_FETCH = 3'd0;
   localparam logic [2:0] CT_MRD   = 3'd1;
   localparam logic [2:0] CT_MWR   = 3'd2;
   localparam logic [2:0] CT_IORD  = 3'd3;
   localparam logic [2:0] CT_IOWR  = 3'd4;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [2:0] cyc;
   logic [2:0] cyc_nxt;
   logic       is_fetch;
   logic       is_io;
   logic       is_final;
   logic       accept;

   assign is_fetch = (cyc == CT_FETCH);
   assign is_io    = (cyc == CT_IORD) || (cyc == CT_IOWR);
   assign is_final = (state == S_T4) || ((state == S_T3) && !is_fetch);
   // Reserved cycle types never get latched, so cyc always holds a legal type.
   assign accept   = start && (cycle_type <= CT_IOWR) &&
                     ((state == S_IDLE) || is_final);

   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc;
      case (state)
         S_IDLE: state_nxt = S_IDLE;
         S_T1:   state_nxt = S_T2;
         S_T2:   state_nxt = (is_io || !nWAIT) ? S_TW : S_T3;
         S_TW:   state_nxt = nWAIT ? S_T3 : S_TW;
         S_T3:   state_nxt = is_fetch ? S_T4 : S_IDLE;
         S_T4:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (accept) begin
         state_nxt = S_T1;
         cyc_nxt   = cycle_type;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cyc   <= CT_FETCH;
      end else begin
         state <= state_nxt;
         cyc   <= cyc_nxt;
      end
   end

   // T4 is only reachable in a fetch and always exits on the next edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_reg <= 8'h00;
      end else if (r_we) begin
         r_reg <= r_in;
      end else if (state == S_T4) begin
         r_reg <= {r_reg[7], r_reg[6:0] + 7'd1};
      end
   end

   always_comb begin
      tstate         = state;
      busy           = (state != S_IDLE);
      done           = is_final;
      pin_control_oe = (state != S_IDLE);
      bus_ab_pin_we  = 1'b0;
      bus_db_pin_re  = 1'b0;
      bus_db_pin_oe  = 1'b0;
      ctl_bus_db_we  = 1'b0;
      rfsh_sel       = 1'b0;
      nM1            = 1'b1;
      nMREQ          = 1'b1;
      nIORQ          = 1'b1;
      nRD            = 1'b1;
      nWR            = 1'b1;
      nRFSH          = 1'b1;
      case (state)
         S_T1: begin
            bus_ab_pin_we = 1'b1;
            case (cyc)
               CT_FETCH: begin
                  nM1   = 1'b0;
                  nMREQ = 1'b0;
                  nRD   = 1'b0;
               end
               CT_MRD: begin
                  nMREQ = 1'b0;
                  nRD   = 1'b0;
               end
               CT_MWR: begin
                  nMREQ         = 1'b0;
                  ctl_bus_db_we = 1'b1;
                  bus_db_pin_oe = 1'b1;
               end
               CT_IOWR: begin
                  ctl_bus_db_we = 1'b1;
                  bus_db_pin_oe = 1'b1;
               end
               default: ;
            endcase
         end
         S_T2, S_TW: begin
            case (cyc)
               CT_FETCH: begin
                  nM1   = 1'b0;
                  nMREQ = 1'b0;
                  nRD   = 1'b0;
               end
               CT_MRD: begin
                  nMREQ = 1'b0;
                  nRD   = 1'b0;
               end
               CT_MWR: begin
                  nMREQ         = 1'b0;
                  nWR           = 1'b0;
                  bus_db_pin_oe = 1'b1;
               end
               CT_IORD: begin
                  nIORQ = 1'b0;
                  nRD   = 1'b0;
               end
               CT_IOWR: begin
                  nIORQ         = 1'b0;
                  nWR           = 1'b0;
                  bus_db_pin_oe = 1'b1;
               end
               default: ;
            endcase
         end
         S_T3: begin
            case (cyc)
               CT_FETCH: begin
                  // Opcode is captured while the refresh address goes out.
                  bus_ab_pin_we = 1'b1;
                  nMREQ         = 1'b0;
                  nRFSH         = 1'b0;
                  rfsh_sel      = 1'b1;
                  bus_db_pin_re = 1'b1;
               end
               CT_MRD: begin
                  nMREQ         = 1'b0;
                  nRD           = 1'b0;
                  bus_db_pin_re = 1'b1;
               end
               CT_MWR: begin
                  nMREQ         = 1'b0;
                  nWR           = 1'b0;
                  bus_db_pin_oe = 1'b1;
               end
               CT_IORD: begin
                  nIORQ         = 1'b0;
                  nRD           = 1'b0;
                  bus_db_pin_re = 1'b1;
               end
               CT_IOWR: begin
                  nIORQ         = 1'b0;
                  nWR           = 1'b0;
                  bus_db_pin_oe = 1'b1;
               end
               default: ;
            endcase
         end
         S_T4: begin
            nMREQ    = 1'b0;
            nRFSH    = 1'b0;
            rfsh_sel = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed vector bench for bus_cycle_sequencer: a per-edge table of inputs
// and hand-derived outputs, plus a wait-state latency sequence.
module tb_bus_cycle_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic [2:0] cycle_type;
   logic       nWAIT;
   logic       r_we;
   logic [7:0] r_in;
   logic       busy;
   logic       done;
   logic [2:0] tstate;
   logic       bus_ab_pin_we;
   logic       pin_control_oe;
   logic       bus_db_pin_re;
   logic       bus_db_pin_oe;
   logic       ctl_bus_db_we;
   logic       rfsh_sel;
   logic [7:0] r_reg;
   logic       nM1;
   logic       nMREQ;
   logic       nIORQ;
   logic       nRD;
   logic       nWR;
   logic       nRFSH;

   int checks = 0;
   int errors = 0;

   bus_cycle_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .cycle_type(cycle_type),
      .nWAIT(nWAIT), .r_we(r_we), .r_in(r_in),
      .busy(busy), .done(done), .tstate(tstate),
      .bus_ab_pin_we(bus_ab_pin_we), .pin_control_oe(pin_control_oe),
      .bus_db_pin_re(bus_db_pin_re), .bus_db_pin_oe(bus_db_pin_oe),
      .ctl_bus_db_we(ctl_bus_db_we), .rfsh_sel(rfsh_sel), .r_reg(r_reg),
      .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
      .nRFSH(nRFSH)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {busy,done,pin_control_oe,bus_ab_pin_we,bus_db_pin_re,bus_db_pin_oe,
   //  ctl_bus_db_we,rfsh_sel, nM1,nMREQ,nIORQ,nRD,nWR,nRFSH}
   logic [13:0] obs;
   assign obs = {busy, done, pin_control_oe, bus_ab_pin_we, bus_db_pin_re,
                 bus_db_pin_oe, ctl_bus_db_we, rfsh_sel,
                 nM1, nMREQ, nIORQ, nRD, nWR, nRFSH};

   localparam logic [13:0] W_IDLE  = 14'b00000000_111111;
   localparam logic [13:0] W_F_T1  = 14'b10110000_001011;
   localparam logic [13:0] W_F_T2  = 14'b10100000_001011;
   localparam logic [13:0] W_F_TW  = 14'b10100000_001011;
   localparam logic [13:0] W_F_T3  = 14'b10111001_101110;
   localparam logic [13:0] W_F_T4  = 14'b11100001_101110;
   localparam logic [13:0] W_MR_T1 = 14'b10110000_101011;
   localparam logic [13:0] W_MR_T2 = 14'b10100000_101011;
   localparam logic [13:0] W_MR_TW = 14'b10100000_101011;
   localparam logic [13:0] W_MR_T3 = 14'b11101000_101011;
   localparam logic [13:0] W_MW_T1 = 14'b10110110_101111;
   localparam logic [13:0] W_MW_T2 = 14'b10100100_101101;
   localparam logic [13:0] W_MW_T3 = 14'b11100100_101101;
   localparam logic [13:0] W_IR_T1 = 14'b10110000_111111;
   localparam logic [13:0] W_IR_T2 = 14'b10100000_110011;
   localparam logic [13:0] W_IR_TW = 14'b10100000_110011;
   localparam logic [13:0] W_IR_T3 = 14'b11101000_110011;
   localparam logic [13:0] W_IW_T1 = 14'b10110110_111111;
   localparam logic [13:0] W_IW_T2 = 14'b10100100_110101;
   localparam logic [13:0] W_IW_TW = 14'b10100100_110101;
   localparam logic [13:0] W_IW_T3 = 14'b11100100_110101;

   typedef struct {
      logic        rst;
      logic        st;
      logic [2:0]  ct;
      logic        nw;
      logic        we;
      logic [7:0]  rin;
      logic [2:0]  ts;
      logic [13:0] ctl;
      logic [7:0]  r;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic st, input logic [2:0] ct,
                      input logic nw, input logic we, input logic [7:0] rin,
                      input logic [2:0] ts, input logic [13:0] ctl,
                      input logic [7:0] r);
      vec_t v;
      v.rst = rst; v.st = st; v.ct = ct; v.nw = nw; v.we = we; v.rin = rin;
      v.ts = ts; v.ctl = ctl; v.r = r;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // Advance one T-state and sample 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      check("db_oe_re_exclusive", {31'd0, bus_db_pin_oe & bus_db_pin_re}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int tw;
      logic seen_done;

      reset = 1'b1; start = 1'b0; cycle_type = 3'd0; nWAIT = 1'b1;
      r_we = 1'b0; r_in = 8'h00;

      //  rst st ct nw we rin    ts ctl      r
      add(1, 0, 0, 1, 0, 8'h00, 0, W_IDLE,  8'h00);
      add(1, 1, 0, 1, 0, 8'h00, 0, W_IDLE,  8'h00); // start ignored in reset
      add(0, 0, 0, 1, 1, 8'h7F, 0, W_IDLE,  8'h7F);
      // fetch, no wait, refresh wraps 0x7F -> 0x00
      add(0, 1, 0, 1, 0, 8'h00, 1, W_F_T1,  8'h7F);
      add(0, 0, 0, 1, 0, 8'h00, 2, W_F_T2,  8'h7F);
      add(0, 0, 0, 1, 0, 8'h00, 4, W_F_T3,  8'h7F);
      add(0, 0, 0, 1, 0, 8'h00, 5, W_F_T4,  8'h7F);
      add(0, 0, 0, 1, 0, 8'h00, 0, W_IDLE,  8'h00);
      // reserved types
      add(0, 1, 5, 1, 0, 8'h00, 0, W_IDLE,  8'h00);
      add(0, 1, 7, 1, 0, 8'h00, 0, W_IDLE,  8'h00);
      // mem read with two waits; start ignored mid-cycle
      add(0, 1, 1, 1, 0, 8'h00, 1, W_MR_T1, 8'h00);
      add(0, 0, 1, 0, 0, 8'h00, 2, W_MR_T2, 8'h00);
      add(0, 1, 0, 0, 0, 8'h00, 3, W_MR_TW, 8'h00);
      add(0, 0, 0, 0, 0, 8'h00, 3, W_MR_TW, 8'h00);
      add(0, 0, 0, 1, 0, 8'h00, 4, W_MR_T3, 8'h00);
      add(0, 0, 0, 1, 0, 8'h00, 0, W_IDLE,  8'h00);
      // mem write, then back-to-back IO write
      add(0, 1, 2, 1, 0, 8'h00, 1, W_MW_T1, 8'h00);
      add(0, 0, 2, 1, 0, 8'h00, 2, W_MW_T2, 8'h00);
      add(0, 0, 2, 1, 0, 8'h00, 4, W_MW_T3, 8'h00);
      add(0, 1, 4, 1, 0, 8'h00, 1, W_IW_T1, 8'h00);
      add(0, 0, 4, 1, 0, 8'h00, 2, W_IW_T2, 8'h00);
      add(0, 0, 4, 1, 0, 8'h00, 3, W_IW_TW, 8'h00);
      add(0, 0, 4, 1, 0, 8'h00, 4, W_IW_T3, 8'h00);
      add(0, 0, 4, 1, 0, 8'h00, 0, W_IDLE,  8'h00);
      // IO read, automatic single wait
      add(0, 1, 3, 1, 0, 8'h00, 1, W_IR_T1, 8'h00);
      add(0, 0, 3, 1, 0, 8'h00, 2, W_IR_T2, 8'h00);
      add(0, 0, 3, 1, 0, 8'h00, 3, W_IR_TW, 8'h00);
      add(0, 0, 3, 1, 0, 8'h00, 4, W_IR_T3, 8'h00);
      add(0, 0, 3, 1, 0, 8'h00, 0, W_IDLE,  8'h00);
      // IO read aborted by reset while in TW
      add(0, 1, 3, 1, 1, 8'hA5, 1, W_IR_T1, 8'hA5);
      add(0, 0, 3, 1, 0, 8'h00, 2, W_IR_T2, 8'hA5);
      add(0, 0, 3, 0, 0, 8'h00, 3, W_IR_TW, 8'hA5);
      add(0, 0, 3, 0, 0, 8'h00, 3, W_IR_TW, 8'hA5);
      add(1, 0, 3, 0, 0, 8'h00, 0, W_IDLE,  8'h00);
      add(0, 1, 3, 1, 0, 8'h00, 1, W_IR_T1, 8'h00);
      add(0, 0, 3, 1, 0, 8'h00, 2, W_IR_T2, 8'h00);
      add(0, 0, 3, 1, 0, 8'h00, 3, W_IR_TW, 8'h00);
      add(0, 0, 3, 1, 0, 8'h00, 4, W_IR_T3, 8'h00);
      add(0, 0, 3, 1, 0, 8'h00, 0, W_IDLE,  8'h00);
      // r_we wins over increment at T4 exit; back-to-back fetch
      add(0, 1, 0, 1, 0, 8'h00, 1, W_F_T1,  8'h00);
      add(0, 0, 0, 1, 0, 8'h00, 2, W_F_T2,  8'h00);
      add(0, 0, 0, 1, 0, 8'h00, 4, W_F_T3,  8'h00);
      add(0, 0, 0, 1, 0, 8'h00, 5, W_F_T4,  8'h00);
      add(0, 1, 0, 1, 1, 8'h85, 1, W_F_T1,  8'h85);
      add(0, 0, 0, 1, 0, 8'h00, 2, W_F_T2,  8'h85);
      add(0, 0, 0, 1, 0, 8'h00, 4, W_F_T3,  8'h85);
      add(0, 0, 0, 1, 0, 8'h00, 5, W_F_T4,  8'h85);
      add(0, 0, 0, 1, 0, 8'h00, 0, W_IDLE,  8'h86);
      // fetch with one wait, bit 7 preserved 0xFF -> 0x80
      add(0, 0, 0, 1, 1, 8'hFF, 0, W_IDLE,  8'hFF);
      add(0, 1, 0, 1, 0, 8'h00, 1, W_F_T1,  8'hFF);
      add(0, 0, 0, 0, 0, 8'h00, 2, W_F_T2,  8'hFF);
      add(0, 0, 0, 0, 0, 8'h00, 3, W_F_TW,  8'hFF);
      add(0, 0, 0, 1, 0, 8'h00, 4, W_F_T3,  8'hFF);
      add(0, 0, 0, 1, 0, 8'h00, 5, W_F_T4,  8'hFF);
      add(0, 0, 0, 1, 0, 8'h00, 0, W_IDLE,  8'h80);

      for (int i = 0; i < vecs.size(); i++) begin
         reset      = vecs[i].rst;
         start      = vecs[i].st;
         cycle_type = vecs[i].ct;
         nWAIT      = vecs[i].nw;
         r_we       = vecs[i].we;
         r_in       = vecs[i].rin;
         step();
         check($sformatf("vec%0d tstate", i), {29'd0, tstate}, {29'd0, vecs[i].ts});
         check($sformatf("vec%0d outputs", i), {18'd0, obs}, {18'd0, vecs[i].ctl});
         check($sformatf("vec%0d r_reg", i), {24'd0, r_reg}, {24'd0, vecs[i].r});
      end

      // Fetch held in wait for three TW states: 4 + 3 = 7 T-states.
      reset = 1'b0; r_we = 1'b0; start = 1'b1; cycle_type = 3'd0; nWAIT = 1'b0;
      step();
      start = 1'b0;
      n = 1; tw = 0; seen_done = 1'b0;
      while (!seen_done && n < 30) begin
         step();
         n++;
         if (tstate == 3'd3) tw++;
         if (tw == 3) nWAIT = 1'b1;
         if (done) seen_done = 1'b1;
      end
      check("wait_fetch_done_seen", {31'd0, seen_done}, 32'd1);
      check("wait_fetch_latency", n, 32'd7);
      check("wait_fetch_tw_count", tw, 32'd3);
      step();
      check("wait_fetch_idle", {29'd0, tstate}, 32'd0);
      check("wait_fetch_r_reg", {24'd0, r_reg}, 32'h81);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
